// File: rtl/mem_arbiter_if.sv
// Bundle of both requester handshakes and the shared Memory bus for mem_arbiter.
// slave = arbiter side, master = requesters plus Memory side.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  rw0;
  logic                  rw1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] dout0;
  logic [DATA_WIDTH-1:0] dout1;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rw;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, din0, din1, mem_dout,
    output gnt0, gnt1, ack0, ack1, dout0, dout1, mem_din, mem_addr, mem_rw, mem_valid
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, din0, din1, mem_dout,
    input  gnt0, gnt1, ack0, ack1, dout0, dout1, mem_din, mem_addr, mem_rw, mem_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single Memory instance.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie (fixed priority).
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t                state_r;
  logic                  owner_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  gnt0_r;
  logic                  gnt1_r;
  logic                  ack0_r;
  logic                  ack1_r;
  logic [DATA_WIDTH-1:0] dout0_r;
  logic [DATA_WIDTH-1:0] dout1_r;
  logic [DATA_WIDTH-1:0] mem_din_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  mem_rw_r;
  logic                  mem_valid_r;
  logic                  pick1_s;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                  last_grant_r;
`endif

  // Winner selection for the IDLE decision: 1 selects port 1.
  always_comb begin
    pick1_s = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      pick1_s = 1'b0;
`else
      pick1_s = ~last_grant_r;
`endif
    end else if (bus.req1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
  end

  // Transaction sequencer; every output is a register set here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      owner_r     <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      dout0_r     <= {DATA_WIDTH{1'b0}};
      dout1_r     <= {DATA_WIDTH{1'b0}};
      mem_din_r   <= {DATA_WIDTH{1'b0}};
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_rw_r    <= 1'b0;
      mem_valid_r <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_r <= 1'b1;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner_r     <= pick1_s;
            gnt0_r      <= ~pick1_s;
            gnt1_r      <= pick1_s;
            mem_rw_r    <= pick1_s ? bus.rw1   : bus.rw0;
            mem_addr_r  <= pick1_s ? bus.addr1 : bus.addr0;
            mem_din_r   <= pick1_s ? bus.din1  : bus.din0;
            mem_valid_r <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant_r <= pick1_s;
`endif
            state_r     <= S_ISSUE;
          end else begin
            state_r     <= S_IDLE;
          end
        end
        S_ISSUE: begin
          mem_valid_r <= 1'b0;
          if (mem_rw_r) begin
            if (owner_r) begin
              ack1_r <= 1'b1;
            end else begin
              ack0_r <= 1'b1;
            end
            state_r <= S_ACK;
          end else begin
            cnt_r   <= CNT_W'(RD_LATENCY);
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          // mem_dout carries the read data during the cnt==1 cycle
          if (cnt_r == CNT_W'(1)) begin
            if (owner_r) begin
              dout1_r <= bus.mem_dout;
              ack1_r  <= 1'b1;
            end else begin
              dout0_r <= bus.mem_dout;
              ack0_r  <= 1'b1;
            end
            state_r <= S_ACK;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        S_ACK: begin
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          ack0_r      <= 1'b0;
          ack1_r      <= 1'b0;
          gnt0_r      <= 1'b0;
          gnt1_r      <= 1'b0;
          mem_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.ack0      = ack0_r;
  assign bus.ack1      = ack1_r;
  assign bus.dout0     = dout0_r;
  assign bus.dout1     = dout1_r;
  assign bus.mem_din   = mem_din_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_rw    = mem_rw_r;
  assign bus.mem_valid = mem_valid_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model on the shared bus.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;
  logic mon_en;
  logic [31:0] mem [256];

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: write on a valid write, read data appears the cycle after valid.
  always @(posedge clk) begin
    if (bus.mem_valid) begin
      if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mutual exclusion of grants; mem_valid only under an active grant.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_overlap", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
      chk("valid_no_gnt", {31'd0, bus.mem_valid & ~(bus.gnt0 | bus.gnt1)}, 32'd0);
    end
  end

  initial begin
    vectors = 0;
    errors  = 0;
    mon_en  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    bus.mem_dout = 32'd0;
    bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = 8'h00; bus.din0 = 32'd0;
    bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = 8'h00; bus.din1 = 32'd0;
    reset = 1'b0;

    // 1: reset
    step(); step();
    chk("rst_gnt0", {31'd0, bus.gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
    chk("rst_ack0", {31'd0, bus.ack0}, 32'd0);
    chk("rst_ack1", {31'd0, bus.ack1}, 32'd0);
    chk("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_rw", {31'd0, bus.mem_rw}, 32'd0);
    chk("rst_addr", {24'd0, bus.mem_addr}, 32'd0);
    chk("rst_din", bus.mem_din, 32'd0);
    chk("rst_dout0", bus.dout0, 32'd0);
    chk("rst_dout1", bus.dout1, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    step();
    chk("idle_gnt0", {31'd0, bus.gnt0}, 32'd0);
    chk("idle_gnt1", {31'd0, bus.gnt1}, 32'd0);

    // 2: port 0 write 04 <- 7
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 8'h04; bus.din0 = 32'h7;
    step();
    chk("wr_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("wr_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("wr_rw", {31'd0, bus.mem_rw}, 32'd1);
    chk("wr_addr", {24'd0, bus.mem_addr}, 32'h04);
    chk("wr_din", bus.mem_din, 32'h7);
    chk("wr_ack0_early", {31'd0, bus.ack0}, 32'd0);
    step();
    chk("wr_ack0", {31'd0, bus.ack0}, 32'd1);
    chk("wr_gnt0_ack", {31'd0, bus.gnt0}, 32'd1);
    chk("wr_valid_off", {31'd0, bus.mem_valid}, 32'd0);
    bus.req0 = 1'b0;
    step();
    chk("wr_ack0_pulse", {31'd0, bus.ack0}, 32'd0);
    chk("wr_gnt0_drop", {31'd0, bus.gnt0}, 32'd0);

    // 3: port 0 read 04
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 8'h04; bus.din0 = 32'd0;
    step();
    chk("rd_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("rd_rw", {31'd0, bus.mem_rw}, 32'd0);
    chk("rd_gnt0", {31'd0, bus.gnt0}, 32'd1);
    step();
    chk("rd_wait_ack0", {31'd0, bus.ack0}, 32'd0);
    chk("rd_wait_valid", {31'd0, bus.mem_valid}, 32'd0);
    step();
    chk("rd_ack0", {31'd0, bus.ack0}, 32'd1);
    chk("rd_dout0", bus.dout0, 32'h7);
    bus.req0 = 1'b0;
    step();
    chk("rd_ack0_pulse", {31'd0, bus.ack0}, 32'd0);
    chk("rd_dout0_hold", bus.dout0, 32'h7);

    // 4: tie from reset state (last_grant = 1), both writes, then a read tie
    reset = 1'b0;
    #1;
    reset = 1'b1;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 8'h10; bus.din0 = 32'hAA;
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 8'h11; bus.din1 = 32'hBB;
    step();
    chk("tie1_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("tie1_gnt1", {31'd0, bus.gnt1}, 32'd0);
    chk("tie1_addr", {24'd0, bus.mem_addr}, 32'h10);
    chk("tie1_din", bus.mem_din, 32'hAA);
    bus.addr1 = 8'h55;
    step();
    chk("tie1_ack0", {31'd0, bus.ack0}, 32'd1);
    chk("tie1_addr_hold", {24'd0, bus.mem_addr}, 32'h10);
    bus.req0 = 1'b0;
    bus.addr1 = 8'h11;
    step();
    chk("tie1_idle_gnt1", {31'd0, bus.gnt1}, 32'd0);
    step();
    chk("tie1_gnt1_next", {31'd0, bus.gnt1}, 32'd1);
    chk("tie1_addr1", {24'd0, bus.mem_addr}, 32'h11);
    chk("tie1_din1", bus.mem_din, 32'hBB);
    step();
    chk("tie1_ack1", {31'd0, bus.ack1}, 32'd1);
    bus.req1 = 1'b0;
    step();
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 8'h11;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 8'h10;
    step();
    chk("tie2_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("tie2_addr", {24'd0, bus.mem_addr}, 32'h11);
    step();
    step();
    chk("tie2_ack0", {31'd0, bus.ack0}, 32'd1);
    chk("tie2_dout0", bus.dout0, 32'hBB);
    chk("tie2_dout1_untouched", bus.dout1, 32'd0);
    bus.req0 = 1'b0;
    step();
    step();
    chk("tie2_gnt1", {31'd0, bus.gnt1}, 32'd1);
    chk("tie2_addr1", {24'd0, bus.mem_addr}, 32'h10);
    step();
    step();
    chk("tie2_ack1", {31'd0, bus.ack1}, 32'd1);
    chk("tie2_dout1", bus.dout1, 32'hAA);
    chk("tie2_dout0_untouched", bus.dout0, 32'hBB);
    bus.req1 = 1'b0;
    step();

    // 5: req1 held high, req0 pulsed -> ownership alternates
    bus.rw0 = 1'b1; bus.addr0 = 8'h30; bus.din0 = 32'h1;
    bus.rw1 = 1'b1; bus.addr1 = 8'h31; bus.din1 = 32'h2;
    bus.req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req0 = 1'b1;
      step();
      chk("alt_gnt0", {31'd0, bus.gnt0}, 32'd1);
      chk("alt_gnt1_low", {31'd0, bus.gnt1}, 32'd0);
      step();
      chk("alt_ack0", {31'd0, bus.ack0}, 32'd1);
      bus.req0 = 1'b0;
      step();
      step();
      chk("alt_gnt1", {31'd0, bus.gnt1}, 32'd1);
      chk("alt_gnt0_low", {31'd0, bus.gnt0}, 32'd0);
      step();
      chk("alt_ack1", {31'd0, bus.ack1}, 32'd1);
      step();
    end
    bus.req1 = 1'b0;
    step();

    // 6: reset during WAIT of a port 1 read
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 8'h10;
    step();
    step();
    chk("rst6_wait_gnt1", {31'd0, bus.gnt1}, 32'd1);
    chk("rst6_wait_ack1", {31'd0, bus.ack1}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst6_gnt1", {31'd0, bus.gnt1}, 32'd0);
    chk("rst6_ack1", {31'd0, bus.ack1}, 32'd0);
    chk("rst6_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst6_addr", {24'd0, bus.mem_addr}, 32'd0);
    chk("rst6_dout0", bus.dout0, 32'd0);
    chk("rst6_dout1", bus.dout1, 32'd0);
    bus.req1 = 1'b0;
    step();
    step();
    chk("rst6_no_ack", {31'd0, bus.ack1}, 32'd0);
    reset = 1'b1;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 8'h11;
    step();
    chk("post_gnt1", {31'd0, bus.gnt1}, 32'd1);
    chk("post_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("post_addr", {24'd0, bus.mem_addr}, 32'h11);
    step();
    step();
    chk("post_ack1", {31'd0, bus.ack1}, 32'd1);
    chk("post_dout1", bus.dout1, 32'hBB);
    bus.req1 = 1'b0;
    step();
    chk("post_ack1_pulse", {31'd0, bus.ack1}, 32'd0);
    chk("post_gnt1_drop", {31'd0, bus.gnt1}, 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
